// File: rtl/tree_mac_accum_writeback.sv
// Tree MAC writeback: groups NUM_CHUNKS partials per (i,k), queues results in a FIFO.
// Optional TREE_MAC_ACC_SAT_EN: saturating accumulation instead of wrap.
module tree_mac_accum_writeback #(
  parameter int DATA_WIDTH      = 8,
  parameter int ACC_WIDTH       = 24,
  parameter int ADDRESS_WIDTH_I = 8,
  parameter int ADDRESS_WIDTH_K = 8,
  parameter int NUM_CHUNKS      = 4,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DATA_WIDTH-1:0]      sum_in,
  input  logic [ADDRESS_WIDTH_I-1:0] addr_i_in,
  input  logic [ADDRESS_WIDTH_K-1:0] addr_k_in,
  input  logic                       val_in,
  output logic [ACC_WIDTH-1:0]       out_data,
  output logic [ADDRESS_WIDTH_I-1:0] out_addr_i,
  output logic [ADDRESS_WIDTH_K-1:0] out_addr_k,
  output logic                       out_val,
  input  logic                       out_rdy,
  input  logic                       err_clr,
  output logic                       err_overflow,
  output logic                       err_addr
);

  localparam int CW = $clog2(NUM_CHUNKS + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = ACC_WIDTH + ADDRESS_WIDTH_I + ADDRESS_WIDTH_K;
  localparam logic [CW-1:0] LAST = CW'(NUM_CHUNKS);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t                     state_q, state_d;
  logic [ACC_WIDTH-1:0]       acc_q, acc_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [ADDRESS_WIDTH_I-1:0] ai_q, ai_d;
  logic [ADDRESS_WIDTH_K-1:0] ak_q, ak_d;

  logic [ACC_WIDTH-1:0]       sum_ext, acc_add, acc_new;
  logic [CW-1:0]              cnt_new;
  logic                       mismatch, start, push, addr_set;
  logic [EW-1:0]              push_data;

  assign sum_ext  = ACC_WIDTH'(sum_in);
  assign mismatch = (addr_i_in != ai_q) || (addr_k_in != ak_q);
  assign start    = (state_q == IDLE) || mismatch;

`ifdef TREE_MAC_ACC_SAT_EN
  logic [ACC_WIDTH:0] acc_wide;
  assign acc_wide = {1'b0, acc_q} + {1'b0, sum_ext};
  assign acc_add  = acc_wide[ACC_WIDTH] ? '1 : acc_wide[ACC_WIDTH-1:0];
`else
  assign acc_add  = acc_q + sum_ext;
`endif

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ai_d      = ai_q;
    ak_d      = ak_q;
    push      = 1'b0;
    addr_set  = 1'b0;
    acc_new   = start ? sum_ext : acc_add;
    cnt_new   = start ? CW'(1) : cnt_q + CW'(1);
    push_data = {acc_new, addr_i_in, addr_k_in};
    if (val_in) begin
      addr_set = (state_q == ACCUM) && mismatch;
      ai_d     = addr_i_in;
      ak_d     = addr_k_in;
      if (cnt_new == LAST) begin
        push    = 1'b1;
        acc_d   = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end else begin
        acc_d   = acc_new;
        cnt_d   = cnt_new;
        state_d = ACCUM;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ai_q    <= '0;
      ak_q    <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ai_q    <= ai_d;
      ak_q    <= ak_d;
    end
  end

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   occ;
  logic          full, pop, do_push, ovf_set;
  logic [EW-1:0] head;

  assign full    = (occ == (AW+1)'(FIFO_DEPTH));
  assign pop     = out_val && out_rdy;
  assign do_push = push && (!full || pop);
  assign ovf_set = push && full && !pop;

  // Storage needs no reset; outputs are gated by out_val.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      occ          <= '0;
      err_overflow <= 1'b0;
      err_addr     <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      occ          <= occ + (AW+1)'(do_push) - (AW+1)'(pop);
      err_overflow <= ovf_set || (err_overflow && !err_clr);
      err_addr     <= addr_set || (err_addr && !err_clr);
    end
  end

  assign out_val    = (occ != '0);
  assign head       = out_val ? mem[rd_ptr] : '0;
  assign out_data   = head[EW-1 -: ACC_WIDTH];
  assign out_addr_i = head[ADDRESS_WIDTH_I+ADDRESS_WIDTH_K-1 -: ADDRESS_WIDTH_I];
  assign out_addr_k = head[ADDRESS_WIDTH_K-1:0];

endmodule

// File: tb/tb_tree_mac_accum_writeback.sv
// Directed bench for tree_mac_accum_writeback.
// Second instance uses ACC_WIDTH=8 for the wrap/saturate case.
module tb_tree_mac_accum_writeback;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  sum_in, ai, ak;
  logic        val_in, out_rdy, err_clr;
  logic [23:0] out_data;
  logic [7:0]  out_ai, out_ak;
  logic        out_val, err_ovf, err_addr;

  logic [7:0]  s8_sum;
  logic        s8_val;
  logic [7:0]  o8_data, o8_ai, o8_ak;
  logic        o8_val, o8_ovf, o8_aerr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tree_mac_accum_writeback dut (
    .clk(clk), .reset(reset),
    .sum_in(sum_in), .addr_i_in(ai), .addr_k_in(ak),
    .val_in(val_in),
    .out_data(out_data), .out_addr_i(out_ai), .out_addr_k(out_ak),
    .out_val(out_val), .out_rdy(out_rdy),
    .err_clr(err_clr), .err_overflow(err_ovf), .err_addr(err_addr)
  );

  tree_mac_accum_writeback #(.ACC_WIDTH(8)) dut8 (
    .clk(clk), .reset(reset),
    .sum_in(s8_sum), .addr_i_in(8'd0), .addr_k_in(8'd0),
    .val_in(s8_val),
    .out_data(o8_data), .out_addr_i(o8_ai), .out_addr_k(o8_ak),
    .out_val(o8_val), .out_rdy(1'b1),
    .err_clr(1'b0), .err_overflow(o8_ovf), .err_addr(o8_aerr)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [7:0] s, input logic [7:0] i,
                      input logic [7:0] k);
    sum_in = s; ai = i; ak = k; val_in = 1'b1;
    tick();
    val_in = 1'b0;
  endtask

  task automatic feed8(input logic [7:0] s);
    s8_sum = s; s8_val = 1'b1;
    tick();
    s8_val = 1'b0;
  endtask

  logic [23:0] exp_d [4];
  logic [7:0]  exp_i [4];
  int          exp8;

  initial begin
    reset = 1'b0; sum_in = '0; ai = '0; ak = '0;
    val_in = 1'b0; out_rdy = 1'b1; err_clr = 1'b0;
    s8_sum = '0; s8_val = 1'b0;
    tick(); tick();
    check("rst_val", out_val, 0);
    check("rst_data", out_data, 0);
    check("rst_ovf", err_ovf, 0);
    check("rst_aerr", err_addr, 0);
    reset = 1'b1;
    tick();

    // back-to-back group
    feed(10, 3, 5); feed(20, 3, 5); feed(30, 3, 5);
    check("b2b_early", out_val, 0);
    feed(40, 3, 5);
    check("b2b_val", out_val, 1);
    check("b2b_data", out_data, 100);
    check("b2b_ai", out_ai, 3);
    check("b2b_ak", out_ak, 5);
    tick();
    check("b2b_pop", out_val, 0);

    // gaps inside a group
    feed(10, 3, 5); tick(); feed(20, 3, 5); tick();
    feed(30, 3, 5); tick(); feed(40, 3, 5);
    check("gap_data", out_data, 100);
    check("gap_val", out_val, 1);
    check("gap_aerr", err_addr, 0);
    check("gap_ovf", err_ovf, 0);
    tick();

    // address change mid-group
    feed(5, 1, 1); feed(5, 1, 1);
    feed(7, 2, 2);
    check("aerr_set", err_addr, 1);
    check("aerr_noout", out_val, 0);
    feed(1, 2, 2); feed(1, 2, 2); feed(1, 2, 2);
    check("aerr_data", out_data, 10);
    check("aerr_ai", out_ai, 2);
    check("aerr_ak", out_ak, 2);
    tick();
    check("aerr_drain", out_val, 0);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("aerr_clr", err_addr, 0);

    // overflow: groups g=0..4, partials g+1 at (g, g+10)
    out_rdy = 1'b0;
    for (int g = 0; g < 5; g++) begin
      for (int c = 0; c < 4; c++) feed(8'(g + 1), 8'(g), 8'(g + 10));
      if (g == 3) check("ovf_none", err_ovf, 0);
    end
    check("ovf_set", err_ovf, 1);
    check("ovf_head", out_data, 4);
    check("ovf_head_ai", out_ai, 0);
    check("ovf_head_ak", out_ak, 10);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("ovf_clr", err_ovf, 0);
    check("ovf_stable", out_data, 4);
    for (int c = 0; c < 3; c++) feed(6, 5, 15);
    out_rdy = 1'b1;
    feed(6, 5, 15);
    out_rdy = 1'b0;
    check("full_pop_noflag", err_ovf, 0);
    exp_d = '{8, 12, 16, 24};
    exp_i = '{1, 2, 3, 5};
    out_rdy = 1'b1;
    for (int n = 0; n < 4; n++) begin
      check("drain_val", out_val, 1);
      check("drain_data", out_data, 32'(exp_d[n]));
      check("drain_ai", out_ai, 32'(exp_i[n]));
      tick();
    end
    check("drain_empty", out_val, 0);

    // 8-bit accumulator: 200+100 wraps to 44 or saturates at 255
`ifdef TREE_MAC_ACC_SAT_EN
    exp8 = 255;
`else
    exp8 = 44;
`endif
    feed8(200); feed8(100); feed8(0); feed8(0);
    check("acc8_val", o8_val, 1);
    check("acc8_data", o8_data, 32'(exp8));
    tick();

    // reset with queued results and an open group
    out_rdy = 1'b0;
    for (int g = 0; g < 2; g++)
      for (int c = 0; c < 4; c++) feed(1, 4, 4);
    feed(9, 4, 4); feed(9, 4, 4);
    check("pre_rst_val", out_val, 1);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_val", out_val, 0);
    check("mid_rst_data", out_data, 0);
    #1 reset = 1'b1;
    out_rdy = 1'b1;
    tick();
    feed(50, 7, 9); feed(50, 7, 9); feed(50, 7, 9); feed(50, 7, 9);
    check("post_rst_data", out_data, 200);
    check("post_rst_ai", out_ai, 7);
    check("post_rst_ak", out_ak, 9);
    check("post_rst_aerr", err_addr, 0);
    tick();
    check("post_rst_empty", out_val, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tree_mac_accum_writeback.md
# tree_mac_accum_writeback

Downstream stage of the tree MAC core. Consumes the core's truncated dot-product partials (sum, row/col address, valid), accumulates NUM_CHUNKS consecutive partials belonging to the same (i,k) output element into a wide accumulator, and queues each completed element in a small output FIFO. The FIFO drains through a valid/ready handshake to the result buffer. The core has no backpressure, so FIFO overflow is detected and flagged, never stalled.

## Interface
- DATA_WIDTH, 8, width of incoming partial sum
- ACC_WIDTH, 24, accumulator / output data width (must be ≥ DATA_WIDTH)
- ADDRESS_WIDTH_I, 8, row address width
- ADDRESS_WIDTH_K, 8, column address width
- NUM_CHUNKS, 4, partials per output element (≥ 1)
- FIFO_DEPTH, 4, output FIFO entries (power of 2, ≥ 2)

- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low (0 = reset asserted)
- sum_in  in  DATA_WIDTH  partial dot product from MAC core
- addr_i_in  in  ADDRESS_WIDTH_I  row address aligned with sum_in
- addr_k_in  in  ADDRESS_WIDTH_K  column address aligned with sum_in
- val_in  in  1  sum_in/addr valid this cycle
- out_data  out  ACC_WIDTH  FIFO head accumulated result
- out_addr_i  out  ADDRESS_WIDTH_I  FIFO head row address
- out_addr_k  out  ADDRESS_WIDTH_K  FIFO head column address
- out_val  out  1  FIFO non-empty
- out_rdy  in  1  consumer accepts head when out_val & out_rdy
- err_clr  in  1  synchronous clear of sticky flags
- err_overflow  out  1  sticky: completed result dropped, FIFO full
- err_addr  out  1  sticky: address changed mid-group

## Operation
- States: IDLE (chunk_cnt = 0, no group open), ACCUM (group open, chunk_cnt in 1..NUM_CHUNKS-1).
- IDLE, val_in=1: acc ← zext(sum_in), latch addr_i_in/addr_k_in, chunk_cnt ← 1; if NUM_CHUNKS = 1 complete immediately and stay IDLE, else → ACCUM.
- ACCUM, val_in=1, addresses equal latched: acc ← acc + zext(sum_in), chunk_cnt+1; on reaching NUM_CHUNKS complete group, chunk_cnt ← 0, → IDLE.
- ACCUM, val_in=1, address mismatch: set err_addr; open group discarded; the incoming partial starts a new group as in IDLE.
- val_in=0: no state change in either state; gaps inside a group allowed.
- Completion: push {acc_final, addr_i, addr_k} to FIFO; acc_final includes the completing partial.
- Arithmetic: unsigned, sum_in zero-extended to ACC_WIDTH, addition wraps modulo 2^ACC_WIDTH (see Configuration).
- FIFO: push on completion if not full, or if full and pop occurs the same cycle (pop frees the slot first). Otherwise result dropped, err_overflow set; accumulation state still returns to IDLE.
- Pop when out_val & out_rdy; head advances; out_* must stay stable while out_val=1 and out_rdy=0.
- Pointers wrap modulo FIFO_DEPTH; occupancy counter 0..FIFO_DEPTH.
- err_clr=1 clears both flags; if a new error occurs the same cycle, set wins.

## Timing
- Reset (asynchronous assert, release synchronous to clk): out_val=0, out_data=0, out_addr_i=0, out_addr_k=0, err_overflow=0, err_addr=0, FIFO empty, chunk_cnt=0, acc=0, state IDLE.
- Reset mid-group or with FIFO occupied: all in-flight partials and queued results discarded.
- Latency: completing partial sampled at edge t → out_val=1 (if FIFO was empty) from t+1 onward.
- Throughput: one partial accepted per cycle, no stall; one pop per cycle.
- Flags rise on the edge after the offending cycle.

## Configuration
- TREE_MAC_ACC_SAT_EN defined: accumulation saturates at 2^ACC_WIDTH−1 (no wrap); result stays saturated for the rest of the group.
- Undefined: accumulation wraps modulo 2^ACC_WIDTH.

## Test plan
- Reset, NUM_CHUNKS=4: partials 10,20,30,40 at addr (3,5) back-to-back, out_rdy=1 → one beat out_data=100, addr (3,5), out_val high the cycle after the 4th partial.
- Same group with one-cycle val_in gaps between partials → identical result 100; no flags.
- Group at (1,1) gets 2 partials, then partial 7 at (2,2) → err_addr=1; later 3 more partials of 1 at (2,2) → out_data=10 at (2,2); no output for (1,1).
- out_rdy=0, FIFO_DEPTH=4: complete 5 groups → first 4 held stable in order, 5th dropped, err_overflow=1; completing a group while full with out_rdy=1 in that cycle → accepted, no flag.
- ACC_WIDTH=8, partials 200,100,0,0: without macro out_data=44; with TREE_MAC_ACC_SAT_EN out_data=255.
- Assert reset mid-group with 2 queued results → out_val=0 immediately; after release a fresh group produces the correct sum uncontaminated.
